// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants for the MEM-stage load/store unit: RISC-V
//               load/store funct3 codes, exception cause codes, FSM encoding
//               and an access-size helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;
    localparam logic [2:0] c_f3_sb  = 3'b000;
    localparam logic [2:0] c_f3_sh  = 3'b001;
    localparam logic [2:0] c_f3_sw  = 3'b010;

    localparam logic [3:0] c_cause_load_misaligned  = 4'd4;
    localparam logic [3:0] c_cause_load_fault       = 4'd5;
    localparam logic [3:0] c_cause_store_misaligned = 4'd6;
    localparam logic [3:0] c_cause_store_fault      = 4'd7;

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_SPLIT  = 2'd2
    } lsu_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1
    } lsu_state_e;
`endif

    // Access size in bytes from funct3[1:0] (illegal code 2'b11 treated as a word)
    function automatic logic [2:0] access_bytes(input logic [1:0] size_code);
        case (size_code)
            2'b00:   access_bytes = 3'd1;
            2'b01:   access_bytes = 3'd2;
            default: access_bytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational byte/half select and sign/zero extension of a
//               32-bit word according to a load funct3 and byte offset.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_byte_off,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/half, then extend per funct3
    always_comb begin
        case (i_byte_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_byte_off[1] ? i_word[31:16] : i_word[15:0];
        case (i_func3)
            c_f3_lb:  o_data = {{24{w_byte[7]}}, w_byte};
            c_f3_lbu: o_data = {24'd0, w_byte};
            c_f3_lh:  o_data = {{16{w_half[15]}}, w_half};
            c_f3_lhu: o_data = {16'd0, w_half};
            c_f3_lw:  o_data = i_word;
            default:  o_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : MEM-stage load/store unit. Accepts one request per handshake,
//               checks legality/bounds/alignment, drives the byte-addressed
//               data memory for one cycle and returns load data or raises an
//               exception. Define MISALIGN_SPLIT_EN to split misaligned
//               in-bounds accesses into byte beats instead of trapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read_ena,
    output logic        mem_write_ena,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [3:0]  exc_cause,
    output logic [31:0] exc_addr
);

    lsu_state_e  r_state, w_state_next;
    logic        r_is_load, r_is_store;
    logic [2:0]  r_func3;
    logic [31:0] r_addr, r_wdata;
    logic [4:0]  r_rd;
    logic        r_wb_valid, r_exc_valid;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data, r_exc_addr;
    logic [3:0]  r_exc_cause, w_cause;
    logic        w_accept, w_illegal, w_oob, w_misaligned, w_take_exc;
    logic [32:0] w_end_addr;

`ifdef MISALIGN_SPLIT_EN
    logic [1:0]  r_beat, r_last_beat;
    logic [23:0] r_asm;
    logic [7:0]  w_beat_wbyte;
    logic [31:0] w_asm_shift, w_asm_word, w_ext_data;
    logic        w_split_done;
`endif

    // ACCESS is always a single (last) beat, so a new request may overlap it
    assign req_ready = reset & ((r_state == ST_IDLE) | (r_state == ST_ACCESS));
    assign w_accept  = req_valid & req_ready & ~flush;

    // Legality, bounds and alignment of the incoming request
    always_comb begin
        if (req_is_store)
            w_illegal = !(req_func3 inside {c_f3_sb, c_f3_sh, c_f3_sw});
        else
            w_illegal = !(req_func3 inside {c_f3_lb, c_f3_lh, c_f3_lw, c_f3_lbu, c_f3_lhu});
        w_end_addr   = {1'b0, req_addr} + {30'd0, access_bytes(req_func3[1:0])} - 33'd1;
        w_oob        = w_end_addr >= 33'(MEM_SIZE);
        w_misaligned = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        if (w_illegal || w_oob)
            w_cause = req_is_load ? c_cause_load_fault : c_cause_store_fault;
        else
            w_cause = req_is_load ? c_cause_load_misaligned : c_cause_store_misaligned;
`ifdef MISALIGN_SPLIT_EN
        w_take_exc = w_illegal | w_oob;
`else
        w_take_exc = w_illegal | w_oob | w_misaligned;
`endif
    end

`ifdef MISALIGN_SPLIT_EN
    // Store byte for the current beat and load-byte assembly (LSB first)
    always_comb begin
        case (r_beat)
            2'd0:    w_beat_wbyte = r_wdata[7:0];
            2'd1:    w_beat_wbyte = r_wdata[15:8];
            2'd2:    w_beat_wbyte = r_wdata[23:16];
            default: w_beat_wbyte = r_wdata[31:24];
        endcase
        w_asm_shift  = {mem_rdata[7:0], r_asm};
        // A two-beat half ends up in the upper half of the shifter
        w_asm_word   = (r_last_beat == 2'd1) ? {16'd0, w_asm_shift[31:16]} : w_asm_shift;
        w_split_done = (r_state == ST_SPLIT) && (r_beat == r_last_beat);
    end

    // Assembled value is already LSB-aligned, so no byte offset is applied
    load_extend u_load_extend (
        .i_word     (w_asm_word),
        .i_func3    (r_func3),
        .i_byte_off (2'b00),
        .o_data     (w_ext_data)
    );
`endif

    // Next state and memory interface drive
    always_comb begin
        w_state_next  = r_state;
        mem_addr      = 32'd0;
        mem_wdata     = 32'd0;
        mem_func3     = 3'd0;
        mem_read_ena  = 1'b0;
        mem_write_ena = 1'b0;
        case (r_state)
            ST_IDLE, ST_ACCESS: begin
                if (r_state == ST_ACCESS) begin
                    mem_addr      = r_addr;
                    mem_wdata     = r_wdata;
                    mem_func3     = r_func3;
                    mem_read_ena  = r_is_load;
                    mem_write_ena = r_is_store & ~flush;
                end
                w_state_next = ST_IDLE;
                if (w_accept && !w_take_exc) begin
`ifdef MISALIGN_SPLIT_EN
                    w_state_next = w_misaligned ? ST_SPLIT : ST_ACCESS;
`else
                    w_state_next = ST_ACCESS;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            ST_SPLIT: begin
                mem_addr      = r_addr + {30'd0, r_beat};
                mem_wdata     = {24'd0, w_beat_wbyte};
                mem_func3     = r_is_load ? c_f3_lbu : c_f3_sb;
                mem_read_ena  = r_is_load;
                mem_write_ena = r_is_store & ~flush;
                if (w_split_done)
                    w_state_next = ST_IDLE;
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
        if (flush)
            w_state_next = ST_IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Capture the accepted request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_func3    <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rd       <= 5'd0;
        end else if (w_accept) begin
            r_is_load  <= req_is_load;
            r_is_store <= req_is_store;
            r_func3    <= req_func3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rd       <= req_rd;
        end
    end

`ifdef MISALIGN_SPLIT_EN
    // Beat counter and load-byte shift register for split accesses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat      <= 2'd0;
            r_last_beat <= 2'd0;
            r_asm       <= 24'd0;
        end else if (w_accept) begin
            r_beat      <= 2'd0;
            r_last_beat <= (req_func3[1:0] == 2'b01) ? 2'd1 : 2'd3;
            r_asm       <= 24'd0;
        end else if (r_state == ST_SPLIT) begin
            r_beat      <= r_beat + 2'd1;
            r_asm       <= w_asm_shift[31:8];
        end
    end
`endif

    // Load write-back pulse; a flush kills the result of the aborted op
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
        end else begin
            r_wb_valid <= 1'b0;
            if (!flush && r_is_load) begin
                if (r_state == ST_ACCESS) begin
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= r_rd;
                    r_wb_data  <= mem_rdata;
                end
`ifdef MISALIGN_SPLIT_EN
                else if (w_split_done) begin
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= r_rd;
                    r_wb_data  <= w_ext_data;
                end
`endif
            end
        end
    end

    // Exception pulse raised the cycle after a trapping request is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exc_valid <= 1'b0;
            r_exc_cause <= 4'd0;
            r_exc_addr  <= 32'd0;
        end else begin
            r_exc_valid <= w_accept & w_take_exc;
            r_exc_cause <= (w_accept & w_take_exc) ? w_cause  : 4'd0;
            r_exc_addr  <= (w_accept & w_take_exc) ? req_addr : 32'd0;
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign exc_valid = r_exc_valid;
    assign exc_cause = r_exc_cause;
    assign exc_addr  = r_exc_addr;

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(mem_read_ena && mem_write_ena));

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Scoreboard bench for mem_stage_lsu with a byte-addressed
//               behavioural data memory and directed load/store vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, req_valid, req_ready, req_is_load, req_is_store;
    logic [2:0]  req_func3, mem_func3;
    logic [31:0] req_addr, req_wdata, mem_addr, mem_wdata, mem_rdata, wb_data, exc_addr;
    logic [4:0]  req_rd, wb_rd;
    logic        mem_read_ena, mem_write_ena, wb_valid, exc_valid;
    logic [3:0]  exc_cause;

    int ntests = 0, nfail = 0, cyc = 0, n_rd = 0, n_wr = 0, n_both = 0;
    int base_rd, base_wr;

    logic [7:0] mem [0:1023];
    bit         preloaded = 1'b0;
    logic [7:0] rb0, rb1, rb2, rb3;

    typedef struct {
        bit          is_exc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  cause;
        logic [31:0] addr;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_stage_lsu #(.MEM_SIZE(1024)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_ena(mem_read_ena),
        .mem_write_ena(mem_write_ena), .mem_func3(mem_func3), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    // Data memory: preload on the first edge, then little-endian writes
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
            mem[10'h010] <= 8'h04; mem[10'h011] <= 8'h03;
            mem[10'h012] <= 8'h02; mem[10'h013] <= 8'h01;
            mem[10'h020] <= 8'h80; mem[10'h021] <= 8'hFF;
            preloaded <= 1'b1;
        end else if (mem_write_ena) begin
            mem[mem_addr[9:0]] <= mem_wdata[7:0];
            if (mem_func3[1:0] != 2'b00) mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
            if (mem_func3[1:0] == 2'b10) begin
                mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
                mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
            end
        end
    end

    // Memory read port with funct3 extension
    always_comb begin
        rb0 = mem[mem_addr[9:0]];
        rb1 = mem[mem_addr[9:0] + 10'd1];
        rb2 = mem[mem_addr[9:0] + 10'd2];
        rb3 = mem[mem_addr[9:0] + 10'd3];
        case (mem_func3)
            3'b000:  mem_rdata = {{24{rb0[7]}}, rb0};
            3'b001:  mem_rdata = {{16{rb1[7]}}, rb1, rb0};
            3'b100:  mem_rdata = {24'd0, rb0};
            3'b101:  mem_rdata = {16'd0, rb1, rb0};
            default: mem_rdata = {rb3, rb2, rb1, rb0};
        endcase
    end

    // Cycle and enable counters
    always @(posedge clk) begin
        cyc++;
        if (mem_read_ena) n_rd++;
        if (mem_write_ena) n_wr++;
        if (mem_read_ena && mem_write_ena) n_both++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a result
    always @(negedge clk) begin : mon
        exp_t e;
        if (wb_valid) begin
            if (exp_q.size() == 0) begin
                ntests++; nfail++;
                $display("FAIL wb_unexpected: actual rd=%0d data=0x%08h required no write-back", wb_rd, wb_data);
            end else begin
                e = exp_q.pop_front();
                chk("wb_kind", {31'd0, e.is_exc}, 32'd0);
                chk("wb_data", wb_data, e.data);
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_latency", cyc, e.cyc);
            end
        end
        if (exc_valid) begin
            if (exp_q.size() == 0) begin
                ntests++; nfail++;
                $display("FAIL exc_unexpected: actual cause=%0d addr=0x%08h required no exception", exc_cause, exc_addr);
            end else begin
                e = exp_q.pop_front();
                chk("exc_kind", {31'd0, e.is_exc}, 32'd1);
                chk("exc_cause", {28'd0, exc_cause}, {28'd0, e.cause});
                chk("exc_addr", exc_addr, e.addr);
                chk("exc_latency", cyc, e.cyc);
            end
        end
    end

    // Issue one request; kind 0 = no result, 1 = write-back, 2 = exception
    task automatic send(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input int kind, input logic [31:0] val, input int lat);
        exp_t e;
        int   guard;
        @(negedge clk);
        req_valid = 1'b1; req_is_load = ld; req_is_store = !ld;
        req_func3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        #1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!req_ready) begin
            ntests++; nfail++;
            $display("FAIL req_ready_timeout: actual req_ready=0 required 1 within 50 cycles");
        end else if (kind != 0) begin
            e.is_exc = (kind == 2);
            e.rd     = rd;
            e.data   = val;
            e.cause  = val[3:0];
            e.addr   = a;
            e.cyc    = cyc + lat;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual simulation still running required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        req_func3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        idle(3); #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
        chk("rst_read_ena", {31'd0, mem_read_ena}, 32'd0);
        chk("rst_write_ena", {31'd0, mem_write_ena}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(negedge clk); reset = 1'b1;

        // Store aborted by reset while in ACCESS
        base_wr = n_wr;
        send(1'b0, c_f3_sw, 32'h10, 32'hDEADBEEF, 5'd0, 0, 32'd0, 0);
        chk("access_write_ena", {31'd0, mem_write_ena}, 32'd1);
        reset = 1'b0; #1;
        chk("reset_kills_write_ena", {31'd0, mem_write_ena}, 32'd0);
        idle(2); reset = 1'b1;
        chk("reset_store_not_written", {mem[10'h013], mem[10'h012], mem[10'h011], mem[10'h010]}, 32'h01020304);
        chk("reset_store_no_write", n_wr - base_wr, 32'd0);
        send(1'b1, c_f3_lw, 32'h10, 32'd0, 5'd1, 1, 32'h01020304, 2);

        // Byte/half extension, issued back-to-back
        send(1'b1, c_f3_lb,  32'h20, 32'd0, 5'd2, 1, 32'hFFFFFF80, 2);
        send(1'b1, c_f3_lbu, 32'h20, 32'd0, 5'd3, 1, 32'h00000080, 2);
        send(1'b1, c_f3_lh,  32'h20, 32'd0, 5'd4, 1, 32'hFFFFFF80, 2);
        send(1'b1, c_f3_lhu, 32'h20, 32'd0, 5'd5, 1, 32'h0000FF80, 2);

        // Store then loads
        send(1'b0, c_f3_sw, 32'h40, 32'h11223344, 5'd0, 0, 32'd0, 0);
        send(1'b1, c_f3_lh, 32'h42, 32'd0, 5'd6, 1, 32'h00001122, 2);
        send(1'b1, c_f3_lw, 32'h40, 32'd0, 5'd7, 1, 32'h11223344, 2);
        idle(3);

`ifdef MISALIGN_SPLIT_EN
        base_wr = n_wr;
        send(1'b0, c_f3_sw, 32'h41, 32'hAABBCCDD, 5'd0, 0, 32'd0, 0);
        idle(5);
        chk("split_store_beats", n_wr - base_wr, 32'd4);
        chk("split_store_bytes", {mem[10'h044], mem[10'h043], mem[10'h042], mem[10'h041]}, 32'hAABBCCDD);
        chk("split_store_neighbour", {24'd0, mem[10'h040]}, 32'h00000044);
        send(1'b1, c_f3_lw, 32'h41, 32'd0, 5'd8, 1, 32'hAABBCCDD, 5);
        idle(6);
`else
        base_rd = n_rd; base_wr = n_wr;
        send(1'b1, c_f3_lw, 32'h41, 32'd0, 5'd8, 2, 32'd4, 1);
        send(1'b0, c_f3_sh, 32'h43, 32'h0000BEEF, 5'd0, 2, 32'd6, 1);
        idle(3);
        chk("misaligned_no_read", n_rd - base_rd, 32'd0);
        chk("misaligned_no_write", n_wr - base_wr, 32'd0);
`endif

        // Bounds and illegal funct3
        send(1'b1, c_f3_lw, 32'h3FE, 32'd0, 5'd9, 2, 32'd5, 1);
        send(1'b1, c_f3_lb, 32'h400, 32'd0, 5'd9, 2, 32'd5, 1);
        send(1'b0, c_f3_sw, 32'h3FD, 32'h12345678, 5'd0, 2, 32'd7, 1);
        send(1'b1, c_f3_lw, 32'h3FC, 32'd0, 5'd9, 1, 32'h00000000, 2);
        send(1'b1, 3'b011, 32'h0, 32'd0, 5'd9, 2, 32'd5, 1);
        send(1'b0, 3'b100, 32'h8, 32'h0, 5'd0, 2, 32'd7, 1);
        idle(3);

        // Flush during a store ACCESS
        base_wr = n_wr;
        send(1'b0, c_f3_sw, 32'h80, 32'h55667788, 5'd0, 0, 32'd0, 0);
        flush = 1'b1; #1;
        chk("flush_gates_write_ena", {31'd0, mem_write_ena}, 32'd0);
        @(posedge clk); #1; flush = 1'b0;
        idle(2);
        chk("flush_store_mem", {mem[10'h083], mem[10'h082], mem[10'h081], mem[10'h080]}, 32'd0);
        chk("flush_store_no_write", n_wr - base_wr, 32'd0);

        // Flush during a load ACCESS: no write-back may appear
        send(1'b1, c_f3_lw, 32'h40, 32'd0, 5'd10, 0, 32'd0, 0);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        idle(3);

        // Flush together with a request: not accepted
        base_rd = n_rd;
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_is_load = 1'b1; req_func3 = c_f3_lw; req_addr = 32'h10; req_rd = 5'd11;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0; req_is_load = 1'b0;
        idle(3);
        chk("flush_req_not_accepted", n_rd - base_rd, 32'd0);

        idle(5);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("rw_enable_overlap", n_both, 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
